// File: rtl/shared_pkg.sv
// Shared AXI4 types for the memory slave: burst/response encodings,
// beat length/size types, the channel FSM states and a burst legality helper.
package shared_pkg;

  typedef enum logic [1:0] {
    FIXED = 2'b00,
    INCR  = 2'b01,
    WRAP  = 2'b10
  } burst_t;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } resp_t;

  typedef logic [7:0] len_t;
  typedef logic [2:0] size_t;

  typedef enum logic [1:0] {
    W_IDLE,
    W_DATA,
    W_RESP
  } wstate_t;

  typedef enum logic {
    R_IDLE,
    R_DATA
  } rstate_t;

  // A burst is rejected as a whole when the beat is wider than the bus, the
  // burst type is the reserved encoding, or a WRAP length is not 2/4/8/16 beats.
  function automatic logic burst_illegal(input len_t len, input size_t size,
                                         input logic [1:0] burst, input size_t max_size);
    logic wrap_len_ok;
    wrap_len_ok = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    return (size > max_size) || (burst == 2'b11) || ((burst == WRAP) && !wrap_len_ok);
  endfunction

endpackage

// File: rtl/axi_burst_addr_gen.sv
// Combinational next-beat address for FIXED, INCR and WRAP bursts.
// WRAP keeps the address inside the aligned window of (len+1)*2**size bytes.
module axi_burst_addr_gen
  import shared_pkg::*;
#(
  parameter int ADDR_WIDTH = 16
) (
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  len_t                  len_i,
  input  size_t                 size_i,
  input  logic [1:0]            burst_i,
  output logic [ADDR_WIDTH-1:0] next_addr_o
);

  logic [ADDR_WIDTH-1:0] step;
  logic [ADDR_WIDTH-1:0] wrap_mask;
  logic [ADDR_WIDTH-1:0] incr_addr;

  // Step by the beat size; for WRAP splice the incremented offset into the fixed window base
  always_comb begin
    step        = ADDR_WIDTH'(1) << size_i;
    wrap_mask   = ((ADDR_WIDTH'(len_i) + ADDR_WIDTH'(1)) << size_i) - ADDR_WIDTH'(1);
    incr_addr   = addr_i + step;
    next_addr_o = addr_i;
    case (burst_i)
      FIXED:   next_addr_o = addr_i;
      INCR:    next_addr_o = incr_addr;
      WRAP:    next_addr_o = (addr_i & ~wrap_mask) | (incr_addr & wrap_mask);
      default: next_addr_o = addr_i;
    endcase
  end

endmodule

// File: rtl/axi4_slave_mem.sv
// AXI4 memory slave with independent read and write channel FSMs over a
// byte-lane memory. FIXED/INCR/WRAP bursts, narrow beats and byte strobes.
// Optional feature macro AXI_ADDR_CHECK_EN: out-of-range word indices give
// SLVERR and are neither written nor read; otherwise the index wraps.
module axi4_slave_mem
  import shared_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16,
  parameter int MEM_DEPTH  = 1024
) (
  input  logic                    aclk,
  input  logic                    areset_n,
  input  logic [ADDR_WIDTH-1:0]   araddr,
  input  logic [7:0]              arlen,
  input  logic [2:0]              arsize,
  input  logic [1:0]              arburst,
  input  logic                    arvalid,
  output logic                    arready,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic [1:0]              rresp,
  output logic                    rlast,
  output logic                    rvalid,
  input  logic                    rready,
  input  logic [ADDR_WIDTH-1:0]   awaddr,
  input  logic [7:0]              awlen,
  input  logic [2:0]              awsize,
  input  logic [1:0]              awburst,
  input  logic                    awvalid,
  output logic                    awready,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  input  logic                    wlast,
  input  logic                    wvalid,
  output logic                    wready,
  output logic [1:0]              bresp,
  output logic                    bvalid,
  input  logic                    bready
);

  localparam int    STRB_W    = DATA_WIDTH / 8;
  localparam int    LANE_BITS = $clog2(STRB_W);
  localparam int    IDX_BITS  = $clog2(MEM_DEPTH);
  localparam size_t MAX_SIZE  = size_t'(LANE_BITS);

  logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];

  function automatic logic [IDX_BITS-1:0] word_idx(input logic [ADDR_WIDTH-1:0] a);
    return IDX_BITS'(a >> LANE_BITS);
  endfunction

  // ---------------- write channel ----------------
  wstate_t               wstate_q, wstate_d;
  logic [ADDR_WIDTH-1:0] waddr_q, waddr_d, waddr_nxt;
  len_t                  wlen_q, wlen_d, wcnt_q, wcnt_d;
  size_t                 wsize_q, wsize_d;
  logic [1:0]            wburst_q, wburst_d;
  logic                  werr_q, werr_d;
  logic                  wslv_q, wslv_d;
  logic                  wbeat_ok, w_hs, w_final, w_write_en;

  axi_burst_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH)) u_waddr_gen (
    .addr_i      (waddr_q),
    .len_i       (wlen_q),
    .size_i      (wsize_q),
    .burst_i     (wburst_q),
    .next_addr_o (waddr_nxt)
  );

`ifdef AXI_ADDR_CHECK_EN
  assign wbeat_ok = (waddr_q >> LANE_BITS) < ADDR_WIDTH'(MEM_DEPTH);
`else
  assign wbeat_ok = 1'b1;
`endif

  assign awready    = (wstate_q == W_IDLE);
  assign wready     = (wstate_q == W_DATA);
  assign bvalid     = (wstate_q == W_RESP);
  assign bresp      = (werr_q || wslv_q) ? SLVERR : OKAY;
  assign w_hs       = wvalid && wready;
  assign w_final    = (wcnt_q == wlen_q);
  assign w_write_en = w_hs && !werr_q && wbeat_ok;

  // Write FSM next state: capture the burst on AW, step per W beat, end on the beat count
  always_comb begin
    wstate_d = wstate_q;
    waddr_d  = waddr_q;
    wlen_d   = wlen_q;
    wsize_d  = wsize_q;
    wburst_d = wburst_q;
    wcnt_d   = wcnt_q;
    werr_d   = werr_q;
    wslv_d   = wslv_q;
    case (wstate_q)
      W_IDLE: if (awvalid) begin
        wstate_d = W_DATA;
        waddr_d  = awaddr;
        wlen_d   = awlen;
        wsize_d  = awsize;
        wburst_d = awburst;
        wcnt_d   = '0;
        werr_d   = burst_illegal(awlen, awsize, awburst, MAX_SIZE);
        wslv_d   = 1'b0;
      end
      W_DATA: if (w_hs) begin
        if ((wlast != w_final) || !wbeat_ok) wslv_d = 1'b1;
        waddr_d = waddr_nxt;
        wcnt_d  = wcnt_q + 8'd1;
        if (w_final) wstate_d = W_RESP;
      end
      W_RESP: if (bready) wstate_d = W_IDLE;
      default: wstate_d = W_IDLE;
    endcase
  end

  // Write FSM state and captured burst context
  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      wstate_q <= W_IDLE;
      waddr_q  <= '0;
      wlen_q   <= '0;
      wsize_q  <= '0;
      wburst_q <= '0;
      wcnt_q   <= '0;
      werr_q   <= 1'b0;
      wslv_q   <= 1'b0;
    end else begin
      wstate_q <= wstate_d;
      waddr_q  <= waddr_d;
      wlen_q   <= wlen_d;
      wsize_q  <= wsize_d;
      wburst_q <= wburst_d;
      wcnt_q   <= wcnt_d;
      werr_q   <= werr_d;
      wslv_q   <= wslv_d;
    end
  end

  // Byte-lane memory write; contents are deliberately left out of reset
  always_ff @(posedge aclk) begin
    if (w_write_en) begin
      for (int i = 0; i < STRB_W; i++) begin
        if (wstrb[i]) mem_q[word_idx(waddr_q)][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  // ---------------- read channel ----------------
  rstate_t               rstate_q, rstate_d;
  logic [ADDR_WIDTH-1:0] raddr_q, raddr_d, raddr_nxt;
  len_t                  rlen_q, rlen_d, rcnt_q, rcnt_d;
  size_t                 rsize_q, rsize_d;
  logic [1:0]            rburst_q, rburst_d;
  logic                  rerr_q, rerr_d;
  logic                  rslv_q, rslv_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [1:0]            rresp_q, rresp_d;
  logic                  rlast_q, rlast_d;
  logic                  rfetch, rbeat_ok;

  axi_burst_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH)) u_raddr_gen (
    .addr_i      (raddr_q),
    .len_i       (rlen_q),
    .size_i      (rsize_q),
    .burst_i     (rburst_q),
    .next_addr_o (raddr_nxt)
  );

  assign arready = (rstate_q == R_IDLE);
  assign rvalid  = (rstate_q == R_DATA);
  assign rdata   = rdata_q;
  assign rresp   = rresp_q;
  assign rlast   = rlast_q;

  // Read FSM next state; a beat is fetched into the output register on AR and on each accepted beat
  always_comb begin
    rstate_d = rstate_q;
    raddr_d  = raddr_q;
    rlen_d   = rlen_q;
    rsize_d  = rsize_q;
    rburst_d = rburst_q;
    rcnt_d   = rcnt_q;
    rerr_d   = rerr_q;
    rslv_d   = rslv_q;
    rdata_d  = rdata_q;
    rresp_d  = rresp_q;
    rlast_d  = rlast_q;
    rfetch   = 1'b0;
    rbeat_ok = 1'b1;
    case (rstate_q)
      R_IDLE: if (arvalid) begin
        rstate_d = R_DATA;
        raddr_d  = araddr;
        rlen_d   = arlen;
        rsize_d  = arsize;
        rburst_d = arburst;
        rcnt_d   = '0;
        rerr_d   = burst_illegal(arlen, arsize, arburst, MAX_SIZE);
        rslv_d   = 1'b0;
        rlast_d  = (arlen == 8'd0);
        rfetch   = 1'b1;
      end
      R_DATA: if (rready) begin
        if (rlast_q) begin
          rstate_d = R_IDLE;
          rlast_d  = 1'b0;
        end else begin
          raddr_d = raddr_nxt;
          rcnt_d  = rcnt_q + 8'd1;
          rlast_d = ((rcnt_q + 8'd1) == rlen_q);
          rfetch  = 1'b1;
        end
      end
      default: rstate_d = R_IDLE;
    endcase
    if (rfetch) begin
`ifdef AXI_ADDR_CHECK_EN
      rbeat_ok = (raddr_d >> LANE_BITS) < ADDR_WIDTH'(MEM_DEPTH);
`endif
      rslv_d  = rslv_d || !rbeat_ok;
      rresp_d = (rerr_d || rslv_d) ? SLVERR : OKAY;
      rdata_d = (rerr_d || !rbeat_ok) ? '0 : mem_q[word_idx(raddr_d)];
    end
  end

  // Read FSM state, burst context and the registered R channel outputs
  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      rstate_q <= R_IDLE;
      raddr_q  <= '0;
      rlen_q   <= '0;
      rsize_q  <= '0;
      rburst_q <= '0;
      rcnt_q   <= '0;
      rerr_q   <= 1'b0;
      rslv_q   <= 1'b0;
      rdata_q  <= '0;
      rresp_q  <= '0;
      rlast_q  <= 1'b0;
    end else begin
      rstate_q <= rstate_d;
      raddr_q  <= raddr_d;
      rlen_q   <= rlen_d;
      rsize_q  <= rsize_d;
      rburst_q <= rburst_d;
      rcnt_q   <= rcnt_d;
      rerr_q   <= rerr_d;
      rslv_q   <= rslv_d;
      rdata_q  <= rdata_d;
      rresp_q  <= rresp_d;
      rlast_q  <= rlast_d;
    end
  end

endmodule

// File: tb/tb_axi4_slave_mem.sv
// Self-checking bench for axi4_slave_mem (default build, 32-bit bus).
// A byte-addressed reference memory tracks every legal write; burst
// addresses are derived arithmetically from the burst rules.
module tb_axi4_slave_mem;

  localparam int DW    = 32;
  localparam int AW    = 16;
  localparam int DEPTH = 1024;

  logic          aclk = 1'b0;
  logic          areset_n;
  logic [AW-1:0] araddr, awaddr;
  logic [7:0]    arlen, awlen;
  logic [2:0]    arsize, awsize;
  logic [1:0]    arburst, awburst;
  logic          arvalid, arready, rlast, rvalid, rready;
  logic [DW-1:0] rdata, wdata;
  logic [1:0]    rresp, bresp;
  logic          awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic [3:0]    wstrb;

  axi4_slave_mem #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MEM_DEPTH(DEPTH)) dut (
    .aclk(aclk), .areset_n(areset_n),
    .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  always #5 aclk = ~aclk;

  int checks = 0;
  int errors = 0;

  logic [7:0]  refMem [DEPTH*4];
  logic [31:0] wrData [256];
  logic [3:0]  wrStrb [256];
  logic [31:0] gotData [256];
  logic [1:0]  gotResp [256];
  logic        gotLast [256];
  int          gotBeats;
  logic [1:0]  lastBresp;
  logic        bvalidPrompt;

  typedef struct packed {
    logic [15:0]      addr;
    logic [7:0]       len;
    logic [2:0]       size;
    logic [1:0]       burst;
    logic [1:0]       expResp;
    logic [3:0][9:0]  expIdx;
  } vec_t;

  vec_t vecs [12];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic reportTimeout(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s: timed out waiting for the DUT", name);
  endtask

  function automatic vec_t mkVec(input logic [15:0] a, input int len, input int size, input int burst,
                                 input int resp, input int i0, input int i1, input int i2, input int i3);
    vec_t v;
    v.addr = a; v.len = 8'(len); v.size = 3'(size); v.burst = 2'(burst); v.expResp = 2'(resp);
    v.expIdx[0] = 10'(i0); v.expIdx[1] = 10'(i1); v.expIdx[2] = 10'(i2); v.expIdx[3] = 10'(i3);
    return v;
  endfunction

  // ---------------- reference model ----------------
  function automatic bit isIllegal(input int len, input int size, input int burst);
    bit wrapOk;
    wrapOk = (len == 1) || (len == 3) || (len == 7) || (len == 15);
    return (size > 2) || (burst == 3) || (burst == 2 && !wrapOk);
  endfunction

  function automatic int beatAddr(input int start, input int len, input int size, input int burst, input int beat);
    int step;
    int total;
    int base;
    int a;
    step = 1 << size;
    case (burst)
      1: a = start + beat * step;
      2: begin
        total = (len + 1) * step;
        base  = start - (start % total);
        a     = base + ((start % total) + beat * step) % total;
      end
      default: a = start;
    endcase
    return a & 16'hFFFF;
  endfunction

  function automatic int wordIdx(input int a);
    return (a >> 2) % DEPTH;
  endfunction

  function automatic logic [31:0] refWord(input int idx);
    return {refMem[idx*4+3], refMem[idx*4+2], refMem[idx*4+1], refMem[idx*4]};
  endfunction

  function automatic void modelWrite(input int addr, input int len, input int size, input int burst);
    int idx;
    if (isIllegal(len, size, burst)) return;
    for (int b = 0; b <= len; b++) begin
      idx = wordIdx(beatAddr(addr, len, size, burst, b));
      for (int l = 0; l < 4; l++) begin
        if (wrStrb[b][l]) refMem[idx*4+l] = wrData[b][8*l +: 8];
      end
    end
  endfunction

  // ---------------- bus tasks ----------------
  task automatic axiWrite(input int addr, input int len, input int size, input int burst, input int wlastBeat);
    int n;
    awaddr = 16'(addr); awlen = 8'(len); awsize = 3'(size); awburst = 2'(burst); awvalid = 1'b1;
    n = 0;
    while (!awready && n < 200) begin @(posedge aclk); #1; n++; end
    if (n >= 200) reportTimeout("aw_handshake");
    @(posedge aclk); #1;
    awvalid = 1'b0;
    for (int b = 0; b <= len; b++) begin
      wvalid = 1'b1; wdata = wrData[b]; wstrb = wrStrb[b]; wlast = (b == wlastBeat);
      n = 0;
      while (!wready && n < 200) begin @(posedge aclk); #1; n++; end
      if (n >= 200) begin reportTimeout("w_handshake"); break; end
      @(posedge aclk); #1;
    end
    wvalid = 1'b0; wlast = 1'b0;
    bvalidPrompt = bvalid;
    bready = 1'b1;
    n = 0;
    while (!bvalid && n < 200) begin @(posedge aclk); #1; n++; end
    if (n >= 200) reportTimeout("b_handshake");
    lastBresp = bresp;
    @(posedge aclk); #1;
    bready = 1'b0;
  endtask

  task automatic axiRead(input int addr, input int len, input int size, input int burst,
                         input int stallBeat, input int stallCycles);
    int n;
    bit done;
    logic [31:0] holdData;
    logic        holdLast;
    araddr = 16'(addr); arlen = 8'(len); arsize = 3'(size); arburst = 2'(burst); arvalid = 1'b1;
    n = 0;
    while (!arready && n < 200) begin @(posedge aclk); #1; n++; end
    if (n >= 200) reportTimeout("ar_handshake");
    @(posedge aclk); #1;
    arvalid = 1'b0;
    checkOutput("rvalid_one_cycle_after_ar", 32'(rvalid), 32'd1);
    gotBeats = 0; done = 1'b0; n = 0;
    while (!done && n < 2000) begin
      if (rvalid) begin
        if (gotBeats == stallBeat) begin
          rready = 1'b0;
          holdData = rdata; holdLast = rlast;
          repeat (stallCycles) begin
            @(posedge aclk); #1;
            checkOutput("stall_rvalid", 32'(rvalid), 32'd1);
            checkOutput("stall_rdata", rdata, holdData);
            checkOutput("stall_rlast", 32'(rlast), 32'(holdLast));
          end
        end
        rready = 1'b1;
        if (gotBeats < 256) begin
          gotData[gotBeats] = rdata; gotResp[gotBeats] = rresp; gotLast[gotBeats] = rlast;
        end
        done = rlast;
        gotBeats++;
      end
      @(posedge aclk); #1;
      n++;
    end
    rready = 1'b0;
    if (!done) reportTimeout("r_burst_end");
    checkOutput("read_beat_count", 32'(gotBeats), 32'(len + 1));
  endtask

  task automatic checkReadModel(input string tag, input int addr, input int len, input int size, input int burst);
    bit ill;
    ill = isIllegal(len, size, burst);
    for (int b = 0; b < gotBeats && b <= len && b < 256; b++) begin
      checkOutput($sformatf("%s_data%0d", tag, b), gotData[b],
                  ill ? 32'd0 : refWord(wordIdx(beatAddr(addr, len, size, burst, b))));
      checkOutput($sformatf("%s_resp%0d", tag, b), 32'(gotResp[b]), ill ? 32'd2 : 32'd0);
      checkOutput($sformatf("%s_last%0d", tag, b), 32'(gotLast[b]), 32'(b == len));
    end
  endtask

  task automatic applyStimulus(input int i);
    vec_t v;
    int beats;
    v = vecs[i];
    axiRead(int'(v.addr), int'(v.len), int'(v.size), int'(v.burst), -1, 0);
    beats = (int'(v.len) + 1 < 4) ? int'(v.len) + 1 : 4;
    for (int b = 0; b < beats && b < gotBeats; b++) begin
      checkOutput($sformatf("tbl%0d_data%0d", i, b), gotData[b],
                  (v.expResp == 2'b10) ? 32'd0 : (32'hC0DE_0000 | 32'(v.expIdx[b])));
      checkOutput($sformatf("tbl%0d_resp%0d", i, b), 32'(gotResp[b]), 32'(v.expResp));
      checkOutput($sformatf("tbl%0d_last%0d", i, b), 32'(gotLast[b]), 32'(b == int'(v.len)));
    end
  endtask

  task automatic randomParams(output int addr, output int len, output int size, output int burst);
    addr  = $urandom_range(0, 511);
    burst = ($urandom_range(0, 9) == 0) ? 3 : $urandom_range(0, 2);
    size  = ($urandom_range(0, 7) == 0) ? 3 : $urandom_range(0, 2);
    len   = $urandom_range(0, 7);
    if (burst == 2 && $urandom_range(0, 4) != 0) begin
      case ($urandom_range(0, 3))
        0: len = 1;
        1: len = 3;
        2: len = 7;
        default: len = 15;
      endcase
    end
  endtask

  initial begin
    #3_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int addr, len, size, burst, rsize;
    areset_n = 1'b0;
    araddr = '0; arlen = '0; arsize = '0; arburst = '0; arvalid = 1'b0; rready = 1'b0;
    awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = 1'b0;
    wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
    repeat (3) @(posedge aclk);
    #1;
    checkOutput("reset_arready", 32'(arready), 32'd1);
    checkOutput("reset_awready", 32'(awready), 32'd1);
    checkOutput("reset_rvalid", 32'(rvalid), 32'd0);
    checkOutput("reset_wready", 32'(wready), 32'd0);
    checkOutput("reset_bvalid", 32'(bvalid), 32'd0);
    checkOutput("reset_rlast", 32'(rlast), 32'd0);
    checkOutput("reset_rdata", rdata, 32'd0);
    checkOutput("reset_rresp", 32'(rresp), 32'd0);
    checkOutput("reset_bresp", 32'(bresp), 32'd0);
    areset_n = 1'b1;
    @(posedge aclk); #1;

    // Preload every word with a recognisable pattern
    for (int blk = 0; blk < 4; blk++) begin
      for (int b = 0; b < 256; b++) begin
        wrData[b] = 32'hC0DE_0000 | 32'(blk * 256 + b);
        wrStrb[b] = 4'hF;
      end
      axiWrite(blk * 1024, 255, 2, 1, 255);
      checkOutput("preload_bresp", 32'(lastBresp), 32'd0);
      modelWrite(blk * 1024, 255, 2, 1);
    end

    // Address-sequence table: expected word indices of the first beats
    vecs[0]  = mkVec(16'h0010, 3, 2, 1, 0,    4,    5,  6,  7);
    vecs[1]  = mkVec(16'h0018, 3, 2, 2, 0,    6,    7,  4,  5);
    vecs[2]  = mkVec(16'h0020, 3, 2, 0, 0,    8,    8,  8,  8);
    vecs[3]  = mkVec(16'h0004, 1, 2, 2, 0,    1,    0,  0,  0);
    vecs[4]  = mkVec(16'h003C, 7, 2, 2, 0,   15,    8,  9, 10);
    vecs[5]  = mkVec(16'h0010, 3, 1, 1, 0,    4,    4,  5,  5);
    vecs[6]  = mkVec(16'h0FFC, 1, 2, 1, 0, 1023,    0,  0,  0);
    vecs[7]  = mkVec(16'h0010, 1, 3, 1, 2,    0,    0,  0,  0);
    vecs[8]  = mkVec(16'h0010, 2, 2, 2, 2,    0,    0,  0,  0);
    vecs[9]  = mkVec(16'h0010, 1, 2, 3, 2,    0,    0,  0,  0);
    vecs[10] = mkVec(16'h0100, 0, 2, 1, 0,   64,    0,  0,  0);
    vecs[11] = mkVec(16'h003E, 15, 0, 2, 0,  15,   15, 12, 12);
    for (int i = 0; i < 12; i++) applyStimulus(i);

    // INCR write 1..4 at 0x10 and read it back
    for (int b = 0; b < 4; b++) begin wrData[b] = 32'(b + 1); wrStrb[b] = 4'hF; end
    axiWrite(16'h10, 3, 2, 1, 3);
    modelWrite(16'h10, 3, 2, 1);
    checkOutput("incr_bresp", 32'(lastBresp), 32'd0);
    checkOutput("incr_bvalid_next_cycle", 32'(bvalidPrompt), 32'd1);
    axiRead(16'h10, 3, 2, 1, -1, 0);
    for (int b = 0; b < 4; b++) begin
      checkOutput($sformatf("incr_rd_data%0d", b), gotData[b], 32'(b + 1));
      checkOutput($sformatf("incr_rd_last%0d", b), 32'(gotLast[b]), 32'(b == 3));
    end

    // Byte strobes merge into existing data
    wrData[0] = 32'h1122_3344; wrStrb[0] = 4'hF;
    axiWrite(16'h40, 0, 2, 1, 0);
    wrData[0] = 32'hAABB_CCDD; wrStrb[0] = 4'b0101;
    axiWrite(16'h40, 0, 2, 1, 0);
    axiRead(16'h40, 0, 2, 1, -1, 0);
    checkOutput("strb_merge", gotData[0], 32'h11BB_33DD);
    wrStrb[0] = 4'hF; wrData[0] = 32'h11BB_33DD;
    modelWrite(16'h40, 0, 2, 1);

    // rready held low for 3 cycles mid-burst
    axiRead(16'h0, 7, 2, 1, 2, 3);
    checkReadModel("stall", 16'h0, 7, 2, 1);

    // Early wlast: burst still runs to the beat count, data kept, SLVERR
    for (int b = 0; b < 4; b++) begin wrData[b] = 32'h5A00_0000 + 32'(b); wrStrb[b] = 4'hF; end
    axiWrite(16'h80, 3, 2, 1, 1);
    checkOutput("early_wlast_bresp", 32'(lastBresp), 32'd2);
    modelWrite(16'h80, 3, 2, 1);
    axiRead(16'h80, 3, 2, 1, -1, 0);
    checkReadModel("early_wlast_rd", 16'h80, 3, 2, 1);

    // Reset pulsed in the middle of a read burst
    araddr = 16'h0; arlen = 8'd7; arsize = 3'd2; arburst = 2'd1; arvalid = 1'b1;
    @(posedge aclk); #1;
    arvalid = 1'b0; rready = 1'b1;
    repeat (2) @(posedge aclk);
    #1;
    checkOutput("pre_reset_rvalid", 32'(rvalid), 32'd1);
    areset_n = 1'b0;
    @(posedge aclk); #1;
    checkOutput("midreset_rvalid", 32'(rvalid), 32'd0);
    checkOutput("midreset_arready", 32'(arready), 32'd1);
    rready = 1'b0; areset_n = 1'b1;
    @(posedge aclk); #1;
    checkOutput("postreset_rvalid", 32'(rvalid), 32'd0);
    checkOutput("postreset_arready", 32'(arready), 32'd1);
    axiRead(16'h10, 3, 2, 1, -1, 0);
    checkReadModel("postreset_rd", 16'h10, 3, 2, 1);

    // Randomised writes and reads against the reference memory
    for (int it = 0; it < 40; it++) begin
      randomParams(addr, len, size, burst);
      for (int b = 0; b <= len; b++) begin
        wrData[b] = $urandom;
        wrStrb[b] = 4'($urandom_range(0, 15));
      end
      axiWrite(addr, len, size, burst, len);
      checkOutput($sformatf("rand%0d_bresp", it), 32'(lastBresp), isIllegal(len, size, burst) ? 32'd2 : 32'd0);
      modelWrite(addr, len, size, burst);
      rsize = (burst == 3 || size == 3) ? size : $urandom_range(0, 2);
      axiRead(addr, len, rsize, burst, $urandom_range(0, len), $urandom_range(0, 2));
      checkReadModel($sformatf("rand%0d", it), addr, len, rsize, burst);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
